// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared VGA timing, colour, mode and playfield geometry for the game renderer
// Geometry is kept as signed 12-bit so edge arithmetic near column/row 0 never wraps.
package game_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  localparam logic [11:0] COL_BALL = 12'hFFF;
  localparam logic [11:0] COL_P1   = 12'hF00;
  localparam logic [11:0] COL_P2   = 12'h00F;
  localparam logic [11:0] COL_WALL = 12'h888;
  localparam logic [11:0] COL_BG   = 12'h000;

  typedef enum logic [1:0] {
    MODE_TENNIS   = 2'b00,
    MODE_SOCCER   = 2'b01,
    MODE_SQUASH   = 2'b10,
    MODE_PRACTICE = 2'b11
  } game_mode_e;

  typedef logic signed [11:0] coord_t;

  localparam coord_t PADDLE_W1   = 12'sd4;
  localparam coord_t PADDLE_BASE = 12'sd4;
  localparam coord_t BAT_SMALL   = 12'sd15;
  localparam coord_t BAT_LARGE   = 12'sd25;
  localparam coord_t P1_X        = 12'sd40;
  localparam coord_t P2_X        = 12'sd596;
  localparam coord_t P1_FWD_X    = 12'sd490;
  localparam coord_t P2_FWD_X    = 12'sd150;
  localparam coord_t SQ_P1_X     = 12'sd490;
  localparam coord_t SQ_P2_X     = 12'sd506;

  localparam coord_t BALL_LO = 12'sd4;
  localparam coord_t BALL_HI = 12'sd3;

  localparam coord_t WALL_TOP_Y0 = 12'sd26;
  localparam coord_t WALL_TOP_Y1 = 12'sd30;
  localparam coord_t WALL_BOT_Y0 = 12'sd450;
  localparam coord_t WALL_BOT_Y1 = 12'sd454;
  localparam coord_t SIDE_L_X0   = 12'sd26;
  localparam coord_t SIDE_L_X1   = 12'sd30;
  localparam coord_t SIDE_R_X0   = 12'sd610;
  localparam coord_t SIDE_R_X1   = 12'sd614;
  localparam coord_t GOAL_Y0     = 12'sd134;
  localparam coord_t GOAL_Y1     = 12'sd344;

  localparam coord_t SCORE_Y0    = 12'sd8;
  localparam coord_t SCORE_Y1    = 12'sd15;
  localparam coord_t SCORE_P1_X  = 12'sd40;
  localparam coord_t SCORE_P2_X  = 12'sd600;

  function automatic coord_t to_coord(input logic [10:0] v);
    return coord_t'({1'b0, v});
  endfunction

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel prescaler, 800x525 raster counters, raw syncs and visible flag
// Counters only move on tick so every downstream register can share the same enable.
module vga_timing
  import game_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible
);

  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PIX_DIV - 1);

  logic [PW-1:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign hsync_raw = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
  assign vsync_raw = !((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END));
  assign visible   = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);

endmodule

// File: rtl/game_renderer.sv
// rtl/game_renderer.sv - frame-snapshot playfield renderer for a VGA bat-and-ball game
// Optional score bars are built only with macro GAME_RENDER_SCORE_EN.
module game_renderer
  import game_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [4:0]  p1_score,
  input  logic [4:0]  p2_score,
  input  logic [1:0]  mode,
  input  logic        bat_size,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  logic       tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       visible;

  vga_timing #(.PIX_DIV(PIX_DIV)) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .visible   (visible)
  );

  // Inputs are sampled once per frame, at the top of vertical blanking.
  logic snap;
  assign snap = tick && (h_cnt == 10'd0) && (v_cnt == V_VISIBLE);

  logic [10:0] sh_p1_y;
  logic [10:0] sh_p2_y;
  logic [10:0] sh_ball_x;
  logic [10:0] sh_ball_y;
  game_mode_e  sh_mode;
  logic        sh_bat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_p1_y   <= '0;
      sh_p2_y   <= '0;
      sh_ball_x <= '0;
      sh_ball_y <= '0;
      sh_mode   <= MODE_TENNIS;
      sh_bat    <= 1'b0;
    end else if (snap) begin
      sh_p1_y   <= p1_y;
      sh_p2_y   <= p2_y;
      sh_ball_x <= ball_x;
      sh_ball_y <= ball_y;
      sh_mode   <= game_mode_e'(mode);
      sh_bat    <= bat_size;
    end
  end

`ifdef GAME_RENDER_SCORE_EN
  logic [4:0] sh_p1_score;
  logic [4:0] sh_p2_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_p1_score <= '0;
      sh_p2_score <= '0;
    end else if (snap) begin
      sh_p1_score <= p1_score;
      sh_p2_score <= p2_score;
    end
  end
`else
  logic unused_scores;
  assign unused_scores = ^{p1_score, p2_score};
`endif

  coord_t hx;
  coord_t vy;
  coord_t half;
  coord_t p1c;
  coord_t p2c;
  coord_t bx;
  coord_t by;

  assign hx   = to_coord({1'b0, h_cnt});
  assign vy   = to_coord({1'b0, v_cnt});
  assign half = PADDLE_BASE + (sh_bat ? BAT_SMALL : BAT_LARGE);
  assign p1c  = to_coord(sh_p1_y);
  assign p2c  = to_coord(sh_p2_y);
  assign bx   = to_coord(sh_ball_x);
  assign by   = to_coord(sh_ball_y);

  logic is_tennis, is_soccer, is_squash, is_practice;
  assign is_tennis   = (sh_mode == MODE_TENNIS);
  assign is_soccer   = (sh_mode == MODE_SOCCER);
  assign is_squash   = (sh_mode == MODE_SQUASH);
  assign is_practice = (sh_mode == MODE_PRACTICE);

  logic ball_hit;
  logic p1_rows, p2_rows;
  logic p1_hit, p2_hit;
  logic wall_hit;
  logic score_hit_p1, score_hit_p2;

  always_comb begin
    ball_hit = in_range(hx, bx - BALL_LO, bx + BALL_HI)
            && in_range(vy, by - BALL_LO, by + BALL_HI);

    p1_rows = in_range(vy, p1c - half, p1c + half);
    p2_rows = in_range(vy, p2c - half, p2c + half);

    p1_hit = p1_rows && (
               ((is_tennis || is_soccer) && in_range(hx, P1_X, P1_X + PADDLE_W1))
            || (is_soccer && in_range(hx, P1_FWD_X, P1_FWD_X + PADDLE_W1))
            || ((is_squash || is_practice) && in_range(hx, SQ_P1_X, SQ_P1_X + PADDLE_W1)));

    // Practice mode has no second player at all.
    p2_hit = p2_rows && (
               ((is_tennis || is_soccer) && in_range(hx, P2_X, P2_X + PADDLE_W1))
            || (is_soccer && in_range(hx, P2_FWD_X, P2_FWD_X + PADDLE_W1))
            || (is_squash && in_range(hx, SQ_P2_X, SQ_P2_X + PADDLE_W1)));

    wall_hit = in_range(vy, WALL_TOP_Y0, WALL_TOP_Y1)
            || in_range(vy, WALL_BOT_Y0, WALL_BOT_Y1)
            || (is_soccer
                && (in_range(hx, SIDE_L_X0, SIDE_L_X1) || in_range(hx, SIDE_R_X0, SIDE_R_X1))
                && !in_range(vy, GOAL_Y0, GOAL_Y1))
            || ((is_squash || is_practice)
                && in_range(hx, SIDE_L_X0, SIDE_L_X1)
                && in_range(vy, WALL_TOP_Y0, WALL_BOT_Y1));

`ifdef GAME_RENDER_SCORE_EN
    // A zero score gives an empty span (hi < lo), so nothing is drawn.
    score_hit_p1 = in_range(vy, SCORE_Y0, SCORE_Y1)
                && in_range(hx, SCORE_P1_X,
                            SCORE_P1_X + coord_t'({5'b0, sh_p1_score, 2'b00}) - 12'sd1);
    score_hit_p2 = in_range(vy, SCORE_Y0, SCORE_Y1)
                && in_range(hx, SCORE_P2_X - coord_t'({5'b0, sh_p2_score, 2'b00}) + 12'sd1,
                            SCORE_P2_X);
`else
    score_hit_p1 = 1'b0;
    score_hit_p2 = 1'b0;
`endif
  end

  logic [11:0] pix;

  always_comb begin
    pix = COL_BG;
    if (ball_hit)          pix = COL_BALL;
    else if (p1_hit)       pix = COL_P1;
    else if (p2_hit)       pix = COL_P2;
    else if (score_hit_p1) pix = COL_P1;
    else if (score_hit_p2) pix = COL_P2;
    else if (wall_hit)     pix = COL_WALL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb        <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap;
      if (tick) begin
        rgb   <= visible ? pix : COL_BG;
        hsync <= hsync_raw;
        vsync <= vsync_raw;
      end
    end
  end

endmodule

// File: tb/tb_game_renderer.sv
// tb/tb_game_renderer.sv - scoreboard bench for game_renderer with hand-computed pixel probes
module tb_game_renderer;

  localparam int PIX_DIV = 2;
`ifdef GAME_RENDER_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif
  localparam logic [11:0] S1 = SCORE_EN ? 12'hF00 : 12'h000;
  localparam logic [11:0] S2 = SCORE_EN ? 12'h00F : 12'h000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] p1_y, p2_y, ball_x, ball_y;
  logic [4:0]  p1_score, p2_score;
  logic [1:0]  mode;
  logic        bat_size;
  logic        hsync, vsync, frame_tick;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  game_renderer #(.PIX_DIV(PIX_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .mode       (mode),
    .bat_size   (bat_size),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int          gen;
    int          frame;
    int          h;
    int          v;
    logic [11:0] rgb;
    string       name;
  } probe_t;

  probe_t sb[$];
  int checks = 0;
  int passes = 0;
  int g_stim = 0;

  int out_gen = -1, out_frame = -1, out_h = -1, out_v = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [13:0] exp_out(input int h, input int v, input logic [11:0] c);
    logic hs, vs;
    hs = !(h >= 656 && h <= 751);
    vs = !(v >= 490 && v <= 491);
    return {c, hs, vs};
  endfunction

  function automatic longint key_of(input int g, input int f, input int v, input int h);
    return longint'(g) * 64'd10_000_000 + longint'(f) * 64'd420_000 + longint'(v) * 64'd800 + longint'(h);
  endfunction

  task automatic px(input int f, input int h, input int v, input logic [11:0] c, input string name);
    probe_t p;
    p.gen = g_stim; p.frame = f; p.h = h; p.v = v; p.rgb = c; p.name = name;
    sb.push_back(p);
  endtask

  // Reference raster position, advanced independently of the DUT.
  initial begin : monitor
    int m_pre, m_h, m_v, m_frame, m_gen, ph, pv, pf;
    bit m_run;
    longint key;
    probe_t p;
    m_pre = 0; m_h = 0; m_v = 0; m_frame = 0; m_gen = 0; m_run = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        if (m_run) m_gen++;
        m_run = 0; m_pre = 0; m_h = 0; m_v = 0; m_frame = 0;
      end else begin
        m_run = 1;
        if (m_pre == PIX_DIV - 1) begin
          ph = m_h; pv = m_v; pf = m_frame;
          m_pre = 0;
          if (m_h == 799) begin
            m_h = 0;
            if (m_v == 524) begin m_v = 0; m_frame++; end
            else m_v++;
          end else m_h++;
          #1;
          out_gen = m_gen; out_frame = pf; out_h = ph; out_v = pv;
          if (ph == 0 && pv == 480) check($sformatf("frame_tick_f%0d", pf), frame_tick, 1);
          else if (frame_tick !== 1'b0) check("frame_tick_spurious", frame_tick, 0);
          key = key_of(m_gen, pf, pv, ph);
          while (sb.size() > 0 && key_of(sb[0].gen, sb[0].frame, sb[0].v, sb[0].h) < key) begin
            p = sb.pop_front();
            checks++;
            $display("FAIL missed_%s: probe never presented, required %h", p.name, p.rgb);
          end
          if (sb.size() > 0 && key_of(sb[0].gen, sb[0].frame, sb[0].v, sb[0].h) == key) begin
            p = sb.pop_front();
            check(p.name, {rgb, hsync, vsync}, exp_out(p.h, p.v, p.rgb));
          end
        end else begin
          m_pre++;
          #1;
          if (frame_tick !== 1'b0) check("frame_tick_spurious", frame_tick, 0);
        end
      end
    end
  end

  initial begin : sync_meas
    int n;
    n = 0;
    while (rst_n !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (hsync !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    n = 0;
    while (hsync === 1'b0 && n < 20000) begin @(negedge clk); n++; end
    check("hsync_low_clk", n, 96 * PIX_DIV);
    while (hsync === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check("hsync_period_clk", n, 800 * PIX_DIV);
    n = 0;
    while (vsync !== 1'b0 && n < 1_500_000) begin @(negedge clk); n++; end
    n = 0;
    while (vsync === 1'b0 && n < 20000) begin @(negedge clk); n++; end
    check("vsync_low_clk", n, 2 * 800 * PIX_DIV);
  end

  task automatic wait_out(input int g, input int f, input int h, input int v, input string what);
    int n;
    n = 0;
    while (!(out_gen == g && out_frame == f && out_h == h && out_v == v) && n < 1_500_000) begin
      @(negedge clk); n++;
    end
    if (n >= 1_500_000) begin
      checks++;
      $display("FAIL timeout_%s: position not reached, required gen %0d frame %0d v %0d h %0d", what, g, f, v, h);
    end
  endtask

  initial begin : watchdog
    #40_000_000;
    checks++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : stimulus
    int n;
    // Frame-1 inputs are applied from the start; frame 0 must still show reset shadows.
    p1_y = 11'd240; p2_y = 11'd240; ball_x = 11'd598; ball_y = 11'd240;
    p1_score = 5'd5; p2_score = 5'd3; mode = 2'b01; bat_size = 1'b1;

    @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb, 0);
    check("rst_frame_tick", frame_tick, 0);

    // Frame 0: all shadows zero -> tennis, ball (0,0), both paddles centred on row 0, half 29.
    px(0, 0, 0, 12'hFFF, "f0_ball_clip");
    px(0, 4, 0, 12'h000, "f0_ball_right_edge");
    px(0, 40, 0, 12'hF00, "f0_p1_clip_top");
    px(0, 3, 3, 12'hFFF, "f0_ball_last");
    px(0, 0, 4, 12'h000, "f0_ball_below");
    px(0, 598, 10, 12'h00F, "f0_p2");
    px(0, 100, 25, 12'h000, "f0_above_wall");
    px(0, 100, 28, 12'h888, "f0_top_wall");
    px(0, 44, 29, 12'hF00, "f0_p1_over_wall");
    px(0, 598, 29, 12'h00F, "f0_p2_over_wall");
    px(0, 42, 30, 12'h888, "f0_p1_end");
    px(0, 655, 100, 12'h000, "f0_hs_655");
    px(0, 656, 100, 12'h000, "f0_hs_656");
    px(0, 751, 100, 12'h000, "f0_hs_751");
    px(0, 752, 100, 12'h000, "f0_hs_752");
    px(0, 100, 452, 12'h888, "f0_bot_wall");
    px(0, 100, 455, 12'h000, "f0_below_wall");
    px(0, 42, 470, 12'h000, "f0_no_wrap");
    px(0, 0, 489, 12'h000, "f0_vs_489");
    px(0, 0, 490, 12'h000, "f0_vs_490");
    px(0, 10, 491, 12'h000, "f0_vs_491");
    px(0, 0, 492, 12'h000, "f0_vs_492");

    // Frame 1: soccer, small bats (half 19), ball overlapping p2 at (598,240), scores 5/3.
    px(1, 40, 10, S1, "f1_score1_first");
    px(1, 59, 10, S1, "f1_score1_last");
    px(1, 60, 10, 12'h000, "f1_score1_after");
    px(1, 588, 10, 12'h000, "f1_score2_before");
    px(1, 589, 10, S2, "f1_score2_first");
    px(1, 600, 10, S2, "f1_score2_last");
    px(1, 28, 100, 12'h888, "f1_side_l");
    px(1, 612, 100, 12'h888, "f1_side_r");
    px(1, 612, 133, 12'h888, "f1_goal_above");
    px(1, 612, 134, 12'h000, "f1_goal_top");
    px(1, 28, 200, 12'h000, "f1_goal_l");
    px(1, 42, 220, 12'h000, "f1_p1_above");
    px(1, 598, 220, 12'h000, "f1_p2_above");
    px(1, 42, 221, 12'hF00, "f1_p1_top");
    px(1, 598, 221, 12'h00F, "f1_p2_top");
    px(1, 594, 236, 12'hFFF, "f1_ball_corner");
    px(1, 596, 236, 12'hFFF, "f1_ball_over_p2");
    px(1, 44, 240, 12'hF00, "f1_p1_mid");
    px(1, 152, 240, 12'h00F, "f1_p2_fwd");
    px(1, 492, 240, 12'hF00, "f1_p1_fwd");
    px(1, 593, 240, 12'h000, "f1_ball_left_out");
    px(1, 598, 240, 12'hFFF, "f1_overlap");
    px(1, 601, 240, 12'hFFF, "f1_ball_right");
    px(1, 602, 240, 12'h000, "f1_ball_right_out");
    px(1, 612, 240, 12'h000, "f1_goal_mouth");
    px(1, 600, 243, 12'hFFF, "f1_ball_last_row");
    px(1, 598, 244, 12'h00F, "f1_p2_below_ball");
    px(1, 42, 259, 12'hF00, "f1_p1_bottom");
    px(1, 42, 260, 12'h000, "f1_p1_below");
    px(1, 612, 344, 12'h000, "f1_goal_bottom");
    px(1, 28, 345, 12'h888, "f1_side_l_low");
    px(1, 612, 345, 12'h888, "f1_side_r_low");

    // Frame 2: squash, ball (100,240), p1_y 240, p2_y 100, large bats (half 29).
    px(2, 45, 12, S1, "f2_score1");
    px(2, 595, 12, S2, "f2_score2");
    px(2, 28, 20, 12'h000, "f2_front_above");
    px(2, 28, 26, 12'h888, "f2_front_top");
    px(2, 508, 70, 12'h000, "f2_p2_above");
    px(2, 508, 71, 12'h00F, "f2_p2_top");
    px(2, 508, 129, 12'h00F, "f2_p2_bottom");
    px(2, 508, 130, 12'h000, "f2_p2_below");
    px(2, 42, 240, 12'h000, "f2_no_tennis_p1");
    px(2, 95, 240, 12'h000, "f2_ball_left_out");
    px(2, 96, 240, 12'hFFF, "f2_ball_left");
    px(2, 103, 240, 12'hFFF, "f2_ball_right");
    px(2, 104, 240, 12'h000, "f2_ball_right_out");
    px(2, 152, 240, 12'h000, "f2_no_fwd");
    px(2, 492, 240, 12'hF00, "f2_p1");
    px(2, 598, 240, 12'h000, "f2_no_p2_old");
    px(2, 28, 300, 12'h888, "f2_front_mid");

    @(negedge clk);
    rst_n = 1'b1;

    // Mid-frame input change: frame 1 must keep its snapshot.
    wait_out(0, 1, 0, 200, "f1_v200");
    ball_x = 11'd100; mode = 2'b10; bat_size = 1'b0; p2_y = 11'd100;

    wait_out(0, 2, 28, 300, "f2_v300");
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", rgb, 0);
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    check("midrst_frame_tick", frame_tick, 0);

    // After a mid-frame reset the shadows are back to zero and the raster restarts.
    g_stim = 1;
    px(0, 2, 2, 12'hFFF, "r_ball");
    px(0, 42, 10, 12'hF00, "r_p1");
    px(0, 598, 10, 12'h00F, "r_p2");
    px(0, 655, 10, 12'h000, "r_hs_655");
    px(0, 656, 10, 12'h000, "r_hs_656");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 100000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d probes left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
